id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have ports: clk in 1 (rising-edge clock); rst_n in 1 (async active-low reset).
REQ-003 SHALL have ports: if_valid in 1, if_ready out 1, if_instr in 32, if_pc in 32 (fetch handshake).
REQ-004 SHALL have ports: read_reg1 out 5, read_reg2 out 5, read_data1 in 32, read_data2 in 32 (register-file read side).
REQ-005 SHALL have ports: wb_enable in 1, wb_reg in 5, wb_data in 32 (writeback, same signals drive register-file write).
REQ-006 SHALL have ports: flush in 1 (kill ID/EX entry); ex_valid out 1, ex_ready in 1 (execute handshake).
REQ-007 SHALL have ports: ex_pc, ex_rs1_data, ex_rs2_data, ex_imm out 32; ex_rd out 5; ex_opcode out 7; ex_funct3 out 3; ex_funct7 out 7; ex_reg_write out 1; ex_illegal out 1.

Function
REQ-008 SHALL drive read_reg1=if_instr[19:15], read_reg2=if_instr[24:20] combinationally.
REQ-009 SHALL generate ex_imm sign-extended per type: I (LOAD, OP-IMM, JALR), S, B, U, J; 0 for OP and illegal.
REQ-010 SHALL set reg_write=1 for LUI, AUIPC, JAL, JALR, LOAD, OP, OP-IMM; 0 for STORE, BRANCH; any other opcode -> ex_illegal=1, reg_write=0.
REQ-011 SHALL keep a 32-bit scoreboard; bit r set when an accepted instruction has reg_write=1 and rd=r!=0; cleared when wb_enable=1 and wb_reg=r; bit 0 never set.
REQ-012 SHALL give set priority over clear when the same register is set and cleared in one cycle.
REQ-013 SHALL assert hazard when rs1 or rs2 (nonzero) has its scoreboard bit set and is not resolved by REQ-020, or when rd (nonzero, reg_write) has its bit set (WAW).
REQ-014 SHALL drive if_ready = !hazard && !flush && (!ex_valid || ex_ready).
REQ-015 SHALL load the ID/EX register on if_valid && if_ready; ex_valid=1 the next cycle; latency 1 cycle.
REQ-016 SHALL hold all ex_* outputs stable while ex_valid && !ex_ready; ex_valid drops after ex_ready with no new accept.
REQ-017 SHALL on flush clear ex_valid next cycle and clear the scoreboard bit of a flushed entry with reg_write=1 (unless set by REQ-012 that cycle).
REQ-018 SHALL force ex_rs1_data/ex_rs2_data to 0 when the respective source is x0.

Reset
REQ-019 SHALL on rst_n=0 asynchronously clear ex_valid, scoreboard, and all ex_* payload to 0; if_ready=0 while in reset.

Configuration
REQ-020 SHALL with FORWARD_EN defined, substitute wb_data for a source when wb_enable=1 and wb_reg equals that nonzero source, treating it as not pending that cycle.
REQ-021 SHALL without FORWARD_EN, treat a matching writeback as still pending, stalling one extra cycle and reading the updated register next cycle.

Structure
REQ-022 SHALL place opcode constants (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011) and imm-type enum in shared package riscv_pkg.
REQ-023 SHALL implement immediate generation in sub-module imm_gen (combinational, instr in, imm out).

Verification
REQ-024 SHALL verify: addi x5,x0,7 (0x00700293) at pc 0x100, ex_ready=1 -> next cycle ex_valid=1, ex_imm=7, ex_rd=5, ex_reg_write=1, scoreboard[5]=1.
REQ-025 SHALL verify: add x6,x5,x5 with scoreboard[5]=1 -> if_ready=0 until wb_enable=1, wb_reg=5, wb_data=0x2A; FORWARD_EN: accept that cycle, ex_rs1_data=ex_rs2_data=0x2A; else accept one cycle later with same data.
REQ-026 SHALL verify: ex_valid=1, ex_ready=0 for 3 cycles, new if_valid -> if_ready=0, ex_* unchanged; ex_ready=1 -> accept next cycle.
REQ-027 SHALL verify: flush with ex_valid entry rd=7 reg_write=1 -> ex_valid=0 next cycle, scoreboard[7]=0.
REQ-028 SHALL verify: opcode 0x7F -> ex_illegal=1, ex_reg_write=0, scoreboard unchanged; beq imm -4 (0xFE000EE3) -> ex_imm=0xFFFFFFFC.
REQ-029 SHALL verify: rst_n=0 mid-stall -> ex_valid=0, scoreboard=0 immediately, no accept until rst_n=1.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32I decode constants, immediate-type enum, decode
//               helpers and the ID/EX pipeline payload record.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    // Payload carried in the ID/EX register
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        reg_write;
        logic        illegal;
    } id_ex_t;

    function automatic imm_type_e imm_type_of(input logic [6:0] opc);
        imm_type_e t;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: t = IMM_I;
            OPC_STORE:                      t = IMM_S;
            OPC_BRANCH:                     t = IMM_B;
            OPC_LUI, OPC_AUIPC:             t = IMM_U;
            OPC_JAL:                        t = IMM_J;
            default:                        t = IMM_NONE;
        endcase
        return t;
    endfunction

    function automatic logic opcode_writes_rd(input logic [6:0] opc);
        return (opc == OPC_LUI)  || (opc == OPC_AUIPC) || (opc == OPC_JAL) ||
               (opc == OPC_JALR) || (opc == OPC_LOAD)  || (opc == OPC_OP)  ||
               (opc == OPC_OP_IMM);
    endfunction

    function automatic logic opcode_is_legal(input logic [6:0] opc);
        return opcode_writes_rd(opc) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen
// Description : Combinational RV32I immediate generator. Selects the I/S/B/U/J
//               format from the opcode and sign-extends; zero otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] imm_o
);

    // Format-dependent bit gathering and sign extension
    always_comb begin
        imm_o = '0;
        case (imm_type_of(instr_i[6:0]))
            IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm_o = {instr_i[31:12], 12'b0};
            IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_stage
// Description : RV32I instruction decode stage with register scoreboard,
//               RAW/WAW hazard stall, flush and ID/EX pipeline register.
//               Optional macro FORWARD_EN: bypass a same-cycle writeback into
//               the source operands instead of stalling one extra cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    // fetch handshake
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    // register-file read side
    output logic [4:0]      read_reg1,
    output logic [4:0]      read_reg2,
    input  logic [XLEN-1:0] read_data1,
    input  logic [XLEN-1:0] read_data2,
    // writeback
    input  logic            wb_enable,
    input  logic [4:0]      wb_reg,
    input  logic [XLEN-1:0] wb_data,
    // execute handshake
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic            ex_reg_write,
    output logic            ex_illegal
);

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        reg_write;
    logic        illegal;

    assign opcode    = if_instr[6:0];
    assign rd        = if_instr[11:7];
    assign funct3    = if_instr[14:12];
    assign rs1       = if_instr[19:15];
    assign rs2       = if_instr[24:20];
    assign funct7    = if_instr[31:25];
    assign read_reg1 = rs1;
    assign read_reg2 = rs2;

    assign illegal   = !opcode_is_legal(opcode);
    assign reg_write = opcode_writes_rd(opcode);

    imm_gen u_imm_gen (
        .instr_i (if_instr),
        .imm_o   (imm)
    );

    // ------------------------------------------------------------------
    // Source operand resolution
    // ------------------------------------------------------------------
    logic [31:0] sb_q;
    logic [31:0] sb_d;
    logic        rs1_pend;
    logic        rs2_pend;
    logic [31:0] src1_raw;
    logic [31:0] src2_raw;

`ifdef FORWARD_EN
    logic wb_hit1;
    logic wb_hit2;
    assign wb_hit1  = wb_enable && (wb_reg == rs1);
    assign wb_hit2  = wb_enable && (wb_reg == rs2);
    // A writeback landing this cycle satisfies the dependency directly
    assign rs1_pend = sb_q[rs1] && !wb_hit1;
    assign rs2_pend = sb_q[rs2] && !wb_hit2;
    assign src1_raw = wb_hit1 ? wb_data : read_data1;
    assign src2_raw = wb_hit2 ? wb_data : read_data2;
`else
    logic unused_wb_data;
    // Without bypass the register file is re-read the cycle after writeback
    assign rs1_pend       = sb_q[rs1];
    assign rs2_pend       = sb_q[rs2];
    assign src1_raw       = read_data1;
    assign src2_raw       = read_data2;
    assign unused_wb_data = ^wb_data;
`endif

    // ------------------------------------------------------------------
    // Hazard detection and handshake
    // ------------------------------------------------------------------
    logic   hazard;
    logic   accept;
    logic   ex_valid_q;
    logic   ex_valid_d;
    id_ex_t ex_q;
    id_ex_t ex_d;

    assign hazard = ((rs1 != 5'd0) && rs1_pend) ||
                    ((rs2 != 5'd0) && rs2_pend) ||
                    (reg_write && (rd != 5'd0) && sb_q[rd]);

    // rst_n term keeps the fetch side stalled while reset is held
    assign if_ready = rst_n && !hazard && !flush && (!ex_valid_q || ex_ready);
    assign accept   = if_valid && if_ready;

    // Next-state for the ID/EX register and its valid flag
    always_comb begin
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;
        if (accept) begin
            ex_d.pc        = if_pc;
            ex_d.rs1_data  = (rs1 == 5'd0) ? 32'd0 : src1_raw;
            ex_d.rs2_data  = (rs2 == 5'd0) ? 32'd0 : src2_raw;
            ex_d.imm       = illegal ? 32'd0 : imm;
            ex_d.rd        = rd;
            ex_d.opcode    = opcode;
            ex_d.funct3    = funct3;
            ex_d.funct7    = funct7;
            ex_d.reg_write = reg_write;
            ex_d.illegal   = illegal;
        end
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    // Scoreboard update: clears first, then sets so a same-cycle set wins
    always_comb begin
        logic [31:0] set_mask;
        logic [31:0] clr_mask;
        set_mask = '0;
        clr_mask = '0;
        if (accept && reg_write) begin
            set_mask[rd] = 1'b1;
        end
        if (wb_enable) begin
            clr_mask[wb_reg] = 1'b1;
        end
        // A killed entry will never write back, so release its destination
        if (flush && ex_valid_q && ex_q.reg_write) begin
            clr_mask[ex_q.rd] = 1'b1;
        end
        sb_d = ((sb_q & ~clr_mask) | set_mask) & ~32'd1;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
            sb_q       <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
            sb_q       <= sb_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ex_valid     = ex_valid_q;
    assign ex_pc        = ex_q.pc;
    assign ex_rs1_data  = ex_q.rs1_data;
    assign ex_rs2_data  = ex_q.rs2_data;
    assign ex_imm       = ex_q.imm;
    assign ex_rd        = ex_q.rd;
    assign ex_opcode    = ex_q.opcode;
    assign ex_funct3    = ex_q.funct3;
    assign ex_funct7    = ex_q.funct7;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_illegal   = ex_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage
// Description : Scoreboard-style bench for id_stage. Stimulus pushes expected
//               ID/EX payloads into a queue; a monitor pops and compares on
//               every ex_valid && ex_ready. Directed checks cover reset,
//               stalls, back-pressure, flush and scoreboard state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        rw;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        wb_enable;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        ex_reg_write;
    logic        ex_illegal;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [31:0] exp_sb;

    // Register-file model
    logic [31:0] rf [32];
    logic        rf_init = 1'b0;

    always #5 clk = ~clk;

    id_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .read_reg1    (read_reg1),
        .read_reg2    (read_reg2),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .wb_enable    (wb_enable),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_pc        (ex_pc),
        .ex_rs1_data  (ex_rs1_data),
        .ex_rs2_data  (ex_rs2_data),
        .ex_imm       (ex_imm),
        .ex_rd        (ex_rd),
        .ex_opcode    (ex_opcode),
        .ex_funct3    (ex_funct3),
        .ex_funct7    (ex_funct7),
        .ex_reg_write (ex_reg_write),
        .ex_illegal   (ex_illegal)
    );

    always @(posedge clk) begin
        if (!rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h1000 + i;
            rf[0] <= 32'd0;
        end else if (wb_enable && wb_reg != 5'd0) begin
            rf[wb_reg] <= wb_data;
        end
    end

    assign read_data1 = (read_reg1 == 5'd0) ? 32'd0 : rf[read_reg1];
    assign read_data2 = (read_reg2 == 5'd0) ? 32'd0 : rf[read_reg2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [31:0] imm,
                                input logic [4:0] rd, input logic [6:0] opc,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic rw, input logic ill);
        exp_t e;
        e.pc = pc; e.r1 = r1; e.r2 = r2; e.imm = imm; e.rd = rd;
        e.opc = opc; e.f3 = f3; e.f7 = f7; e.rw = rw; e.ill = ill;
        return e;
    endfunction

    // Monitor: compare every transfer into execute against the queue head
    always @(negedge clk) begin
        if (rst_n && ex_valid && ex_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected: got pc %h expected no output", ex_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_pc",  ex_pc,       mon_e.pc);
                chk("out_rs1", ex_rs1_data, mon_e.r1);
                chk("out_rs2", ex_rs2_data, mon_e.r2);
                chk("out_imm", ex_imm,      mon_e.imm);
                chk("out_rd",  {27'd0, ex_rd},     {27'd0, mon_e.rd});
                chk("out_opc", {25'd0, ex_opcode}, {25'd0, mon_e.opc});
                chk("out_f3",  {29'd0, ex_funct3}, {29'd0, mon_e.f3});
                chk("out_f7",  {25'd0, ex_funct7}, {25'd0, mon_e.f7});
                chk("out_rw",  {31'd0, ex_reg_write}, {31'd0, mon_e.rw});
                chk("out_ill", {31'd0, ex_illegal},   {31'd0, mon_e.ill});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Present one instruction and wait (bounded) for it to be accepted
    task automatic send(input logic [31:0] pc, input logic [31:0] instr,
                        input exp_t e, input bit expect_out);
        bit done;
        done     = 1'b0;
        if_valid = 1'b1;
        if_pc    = pc;
        if_instr = instr;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (if_ready) begin
                if (expect_out) exp_q.push_back(e);
                done = 1'b1;
            end
            step();
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept for pc %h expected accept", pc);
        end
        if_valid = 1'b0;
        if_instr = 32'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
        wb_enable = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
        flush = 1'b0; ex_ready = 1'b1; exp_sb = 32'd0;

        // Reset state
        idle(3);
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
        chk("rst_sb",       dut.sb_q, 32'd0);
        chk("rst_ex_pc",    ex_pc, 32'd0);
        rf_init = 1'b1;
        rst_n   = 1'b1;
        idle(1);

        // addi x5,x0,7 at 0x100
        send(32'h100, 32'h00700293,
             mk(32'h100, 32'd0, 32'h1007, 32'd7, 5'd5, 7'h13, 3'd0, 7'd0, 1'b1, 1'b0), 1'b1);
        exp_sb[5] = 1'b1;
        @(negedge clk);
        chk("addi_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("addi_imm", ex_imm, 32'd7);
        chk("addi_sb",  dut.sb_q, exp_sb);
        step();

        // add x6,x5,x5: RAW stall until writeback of x5
        if_valid = 1'b1; if_pc = 32'h104; if_instr = 32'h00528333;
        @(negedge clk); chk("raw_stall0", {31'd0, if_ready}, 32'd0); step();
        @(negedge clk); chk("raw_stall1", {31'd0, if_ready}, 32'd0); step();
        wb_enable = 1'b1; wb_reg = 5'd5; wb_data = 32'h2A;
        @(negedge clk);
`ifdef FORWARD_EN
        chk("raw_wb_cycle", {31'd0, if_ready}, 32'd1);
        exp_q.push_back(mk(32'h104, 32'h2A, 32'h2A, 32'd0, 5'd6, 7'h33, 3'd0, 7'd0, 1'b1, 1'b0));
        step();
        wb_enable = 1'b0;
`else
        chk("raw_wb_cycle", {31'd0, if_ready}, 32'd0);
        step();
        wb_enable = 1'b0;
        @(negedge clk);
        chk("raw_after_wb", {31'd0, if_ready}, 32'd1);
        exp_q.push_back(mk(32'h104, 32'h2A, 32'h2A, 32'd0, 5'd6, 7'h33, 3'd0, 7'd0, 1'b1, 1'b0));
        step();
`endif
        if_valid = 1'b0; if_instr = 32'd0;
        exp_sb[5] = 1'b0; exp_sb[6] = 1'b1;
        idle(2);
        chk("raw_sb", dut.sb_q, exp_sb);

        // Back-pressure: lui x8 held while auipc x9 waits
        ex_ready = 1'b0;
        send(32'h200, 32'h12345437,
             mk(32'h200, 32'h1008, 32'h1003, 32'h12345000, 5'd8, 7'h37, 3'd5, 7'h09, 1'b1, 1'b0), 1'b1);
        exp_sb[8] = 1'b1;
        if_valid = 1'b1; if_pc = 32'h204; if_instr = 32'h00001497;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ex_valid", {31'd0, ex_valid}, 32'd1);
            chk("bp_hold_pc",  ex_pc, 32'h200);
            chk("bp_hold_imm", ex_imm, 32'h12345000);
            chk("bp_if_ready", {31'd0, if_ready}, 32'd0);
            step();
        end
        ex_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {31'd0, if_ready}, 32'd1);
        exp_q.push_back(mk(32'h204, 32'd0, 32'd0, 32'h1000, 5'd9, 7'h17, 3'd1, 7'd0, 1'b1, 1'b0));
        step();
        if_valid = 1'b0; if_instr = 32'd0;
        exp_sb[9] = 1'b1;
        @(negedge clk);
        chk("bp_next_pc", ex_pc, 32'h204);
        step();
        idle(1);

        // Flush of pending addi x7
        ex_ready = 1'b0;
        send(32'h208, 32'h00100393, mk(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 7'd0, 3'd0, 7'd0, 1'b0, 1'b0), 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_if_ready", {31'd0, if_ready}, 32'd0);
        chk("flush_sb7_set",  {31'd0, dut.sb_q[7]}, 32'd1);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_sb", dut.sb_q, exp_sb);
        step();
        ex_ready = 1'b1;

        // Illegal opcode, branch, store, jal
        send(32'h300, 32'h0000057F,
             mk(32'h300, 32'd0, 32'd0, 32'd0, 5'd10, 7'h7F, 3'd0, 7'd0, 1'b0, 1'b1), 1'b1);
        @(negedge clk);
        chk("ill_flag", {31'd0, ex_illegal}, 32'd1);
        chk("ill_rw",   {31'd0, ex_reg_write}, 32'd0);
        chk("ill_sb",   dut.sb_q, exp_sb);
        step();
        send(32'h304, 32'hFE000EE3,
             mk(32'h304, 32'd0, 32'd0, 32'hFFFFFFFC, 5'd29, 7'h63, 3'd0, 7'h7F, 1'b0, 1'b0), 1'b1);
        @(negedge clk);
        chk("beq_imm", ex_imm, 32'hFFFFFFFC);
        step();
        send(32'h308, 32'h0020A423,
             mk(32'h308, 32'h1001, 32'h1002, 32'd8, 5'd8, 7'h23, 3'd2, 7'd0, 1'b0, 1'b0), 1'b1);
        send(32'h30C, 32'h010000EF,
             mk(32'h30C, 32'd0, 32'h1010, 32'd16, 5'd1, 7'h6F, 3'd0, 7'd0, 1'b1, 1'b0), 1'b1);
        exp_sb[1] = 1'b1;

        // WAW on x8: stalls through the writeback cycle in both builds
        if_valid = 1'b1; if_pc = 32'h310; if_instr = 32'h00300413;
        @(negedge clk); chk("waw_stall", {31'd0, if_ready}, 32'd0); step();
        wb_enable = 1'b1; wb_reg = 5'd8; wb_data = 32'h55;
        @(negedge clk); chk("waw_wb_cycle", {31'd0, if_ready}, 32'd0); step();
        wb_enable = 1'b0;
        @(negedge clk);
        chk("waw_accept", {31'd0, if_ready}, 32'd1);
        exp_q.push_back(mk(32'h310, 32'd0, 32'h1003, 32'd3, 5'd8, 7'h13, 3'd0, 7'd0, 1'b1, 1'b0));
        step();

        // Set wins over a same-cycle clear of x11
        if_pc = 32'h314; if_instr = 32'h00000593;
        wb_enable = 1'b1; wb_reg = 5'd11; wb_data = 32'h77;
        @(negedge clk);
        chk("prio_accept", {31'd0, if_ready}, 32'd1);
        exp_q.push_back(mk(32'h314, 32'd0, 32'd0, 32'd0, 5'd11, 7'h13, 3'd0, 7'd0, 1'b1, 1'b0));
        step();
        wb_enable = 1'b0; if_valid = 1'b0; if_instr = 32'd0;
        exp_sb[11] = 1'b1;
        @(negedge clk);
        chk("prio_sb", dut.sb_q, exp_sb);
        step();
        idle(1);

        // Reset asserted during a RAW stall on x6
        if_valid = 1'b1; if_pc = 32'h400; if_instr = 32'h00030633;
        @(negedge clk); chk("rst_pre_stall", {31'd0, if_ready}, 32'd0); step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_mid_sb",       dut.sb_q, 32'd0);
        chk("rst_mid_if_ready", {31'd0, if_ready}, 32'd0);
        @(negedge clk); chk("rst_hold_ready", {31'd0, if_ready}, 32'd0); step();
        @(negedge clk); chk("rst_hold_valid", {31'd0, ex_valid}, 32'd0); step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", {31'd0, if_ready}, 32'd1);
        exp_q.push_back(mk(32'h400, 32'h1006, 32'd0, 32'd0, 5'd12, 7'h33, 3'd0, 7'd0, 1'b1, 1'b0));
        step();
        if_valid = 1'b0; if_instr = 32'd0;
        idle(3);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
